mem_stage: RTL and testbench

- MIPS pipeline MEM stage: the consumer of the 106-bit EX_MEM bundle produced by the execute stage.
- Runs the load/store on a req/ready data-memory bus and stalls the upstream pipeline while an access is outstanding.
- Supplies the MEM-stage forwarding signals and registers the 38-bit MEM_WB bundle for write-back.

---
 rtl/mem_stage_if.sv | 38 +++
 rtl/mem_stage.sv | 201 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Data-memory request/ready bus between the MEM pipeline stage and the data
// memory.
//   mem_req   : bus request, held high for the whole outstanding access
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word address
//   mem_wdata : store data
//   mem_rdata : read data, valid while mem_ready is high
//   mem_ready : transaction complete
// The master modport is the pipeline side; the slave modport is the memory.
// -----------------------------------------------------------------------------
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// MIPS pipeline MEM stage. Consumes the 106-bit EX_MEM bundle, performs the
// load/store on a req/ready data bus, stalls upstream while an access is
// outstanding, drives the MEM-stage forwarding signals and registers the
// 38-bit MEM_WB bundle.
//
// Ports
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   EX_MEM[105:0]      : {PC+4, MemtoReg, RegWrite, MemWrite, MemRead,
//                         write reg, ALU result/address, store data}
//   mem_bus            : data-memory bus (master side)
//   mem_stall          : upstream must hold EX_MEM and earlier stages
//   MEM_RegWrite / MEM_WriteRegister / MEM_RegWriteData : forwarding
//   MEM_WB[37:0]       : {RegWrite, write reg, write data}
//   mem_misalign       : one-cycle pulse, registered alongside MEM_WB
//   mem_bus_err        : one-cycle pulse, registered alongside MEM_WB
//
// Parameter
//   TIMEOUT (1..255)   : max BUSY cycles waiting for mem_ready before abort
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [105:0]   EX_MEM,
    mem_stage_if.master    mem_bus,
    output logic           mem_stall,
    output logic           MEM_RegWrite,
    output logic [4:0]     MEM_WriteRegister,
    output logic [31:0]    MEM_RegWriteData,
    output logic [37:0]    MEM_WB,
    output logic           mem_misalign,
    output logic           mem_bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last counter value allowed in BUSY before the access is aborted.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    // EX_MEM field decode
    logic [31:0] ex_wdata_s;
    logic [31:0] ex_alu_s;
    logic [4:0]  ex_reg_s;
    logic        ex_mem_read_s;
    logic        ex_mem_write_s;
    logic        ex_reg_write_s;
    logic [1:0]  ex_memtoreg_s;
    logic [31:0] ex_pc4_s;
    logic        access_s;
    logic        aligned_s;
    logic [31:0] normal_data_s;

    assign ex_wdata_s     = EX_MEM[31:0];
    assign ex_alu_s       = EX_MEM[63:32];
    assign ex_reg_s       = EX_MEM[68:64];
    assign ex_mem_read_s  = EX_MEM[69];
    assign ex_mem_write_s = EX_MEM[70];
    assign ex_reg_write_s = EX_MEM[71];
    assign ex_memtoreg_s  = EX_MEM[73:72];
    assign ex_pc4_s       = EX_MEM[105:74];

    assign access_s      = ex_mem_read_s | ex_mem_write_s;
    assign aligned_s     = (ex_alu_s[1:0] == 2'b00);
    // Link (MemtoReg=10) writes PC+4; every other non-load encoding writes the ALU result.
    assign normal_data_s = (ex_memtoreg_s == 2'b10) ? ex_pc4_s : ex_alu_s;

    // Forwarding is purely combinational from EX_MEM in every state.
    assign MEM_RegWrite      = ex_reg_write_s;
    assign MEM_WriteRegister = ex_reg_s;
    assign MEM_RegWriteData  = normal_data_s;

    // Registered state
    state_t      state_q,    state_d;
    logic        req_q,      req_d;
    logic        we_q,       we_d;
    logic [7:0]  cnt_q,      cnt_d;
    logic [31:0] rdata_q,    rdata_d;
    logic        err_q,      err_d;
    logic [37:0] wb_q,       wb_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q,  bus_err_d;

    // Address and data come straight from EX_MEM, which upstream holds while stalled.
    assign mem_bus.mem_req   = req_q;
    assign mem_bus.mem_we    = we_q;
    assign mem_bus.mem_addr  = ex_alu_s;
    assign mem_bus.mem_wdata = ex_wdata_s;

    assign MEM_WB       = wb_q;
    assign mem_misalign = misalign_q;
    assign mem_bus_err  = bus_err_q;

    // State and output registers, cleared asynchronously so a reset mid-access drops mem_req at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= 8'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
            wb_q       <= 38'd0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            wb_q       <= wb_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Next-state, stall and MEM_WB selection for the IDLE/BUSY/DONE access sequence.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        wb_d       = 38'd0;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        mem_stall  = 1'b0;

        case (state_q)
            IDLE: begin
                if (access_s) begin
                    if (aligned_s) begin
                        // Launch the access; MEM_WB gets a bubble until DONE.
                        mem_stall = 1'b1;
                        state_d   = BUSY;
                        req_d     = 1'b1;
                        // Read+write together is treated as a write.
                        we_d      = ex_mem_write_s;
                        cnt_d     = 8'd0;
                        wb_d      = 38'd0;
                    end else begin
                        // Misaligned: suppress the access and the register write.
                        wb_d       = {1'b0, ex_reg_s, 32'd0};
                        misalign_d = 1'b1;
                    end
                end else begin
                    wb_d = {ex_reg_write_s, ex_reg_s, normal_data_s};
                end
            end

            BUSY: begin
                mem_stall = 1'b1;
                wb_d      = 38'd0;
                if (mem_bus.mem_ready) begin
                    // Ready wins even on the final timeout cycle.
                    rdata_d = mem_bus.mem_rdata;
                    cnt_d   = 8'd0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    rdata_d = 32'd0;
                    cnt_d   = 8'd0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            DONE: begin
                // EX_MEM advances on this edge; an aborted access never writes back.
                wb_d      = {ex_reg_write_s & ~err_q, ex_reg_s,
                             (ex_memtoreg_s == 2'b01) ? rdata_q : normal_data_s};
                bus_err_d = err_q;
                err_d     = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
                cnt_d   = 8'd0;
                err_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage (TIMEOUT=4): a table of single-cycle
// vectors (ALU, jal, misaligned accesses) followed by hand-written multi-cycle
// sequences for load, store, timeout and reset during an access.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic          clk;
    logic          rst_n;
    logic [105:0]  EX_MEM;
    logic          mem_stall;
    logic          MEM_RegWrite;
    logic [4:0]    MEM_WriteRegister;
    logic [31:0]   MEM_RegWriteData;
    logic [37:0]   MEM_WB;
    logic          mem_misalign;
    logic          mem_bus_err;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .EX_MEM            (EX_MEM),
        .mem_bus           (bus),
        .mem_stall         (mem_stall),
        .MEM_RegWrite      (MEM_RegWrite),
        .MEM_WriteRegister (MEM_WriteRegister),
        .MEM_RegWriteData  (MEM_RegWriteData),
        .MEM_WB            (MEM_WB),
        .mem_misalign      (mem_misalign),
        .mem_bus_err       (mem_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int req_cnt = 0;
    int stall_cnt = 0;

    // Count cycles with mem_req / mem_stall high, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_req === 1'b1) req_cnt++;
        if (mem_stall === 1'b1) stall_cnt++;
    end

    typedef struct {
        logic [105:0] ex;
        logic [37:0]  wb;
        logic         stall;
        logic [31:0]  fwd_data;
        logic         mis;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [105:0] mk(input logic [31:0] pc4, input logic [1:0] mtr,
                                        input logic rw, input logic mw, input logic mr,
                                        input logic [4:0] rg, input logic [31:0] alu,
                                        input logic [31:0] wd);
        return {pc4, mtr, rw, mw, mr, rg, alu, wd};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [105:0] nop;
    int rs;
    int ss;

    initial begin
        nop = mk(32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);

        //           ex                                                                           wb                                     stall fwd_data       mis
        vecs[0] = '{mk(32'h0040_0004, 2'b00, 1'b1, 1'b0, 1'b0, 5'd8,  32'h0000_1234, 32'h0), {1'b1, 5'd8,  32'h0000_1234}, 1'b0, 32'h0000_1234, 1'b0};
        vecs[1] = '{mk(32'h0040_0008, 2'b10, 1'b1, 1'b0, 1'b0, 5'd31, 32'h0000_0055, 32'h0), {1'b1, 5'd31, 32'h0040_0008}, 1'b0, 32'h0040_0008, 1'b0};
        vecs[2] = '{mk(32'h0000_0010, 2'b11, 1'b1, 1'b0, 1'b0, 5'd3,  32'hA5A5_0000, 32'h0), {1'b1, 5'd3,  32'hA5A5_0000}, 1'b0, 32'hA5A5_0000, 1'b0};
        vecs[3] = '{mk(32'h0000_0014, 2'b00, 1'b0, 1'b0, 1'b0, 5'd4,  32'h0000_0077, 32'h0), {1'b0, 5'd4,  32'h0000_0077}, 1'b0, 32'h0000_0077, 1'b0};
        vecs[4] = '{mk(32'h0000_0018, 2'b01, 1'b1, 1'b0, 1'b1, 5'd9,  32'h0000_0102, 32'h0), {1'b0, 5'd9,  32'h0000_0000}, 1'b0, 32'h0000_0102, 1'b1};
        vecs[5] = '{mk(32'h0000_001C, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_0101, 32'h1), {1'b0, 5'd0,  32'h0000_0000}, 1'b0, 32'h0000_0101, 1'b1};
        vecs[6] = '{mk(32'h0000_0020, 2'b00, 1'b1, 1'b0, 1'b0, 5'd7,  32'h0000_0abc, 32'h0), {1'b1, 5'd7,  32'h0000_0abc}, 1'b0, 32'h0000_0abc, 1'b0};

        rst_n = 1'b0;
        EX_MEM = nop;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb",       64'(MEM_WB),       64'd0);
        check("rst_req",      64'(bus.mem_req),  64'd0);
        check("rst_we",       64'(bus.mem_we),   64'd0);
        check("rst_misalign", 64'(mem_misalign), 64'd0);
        check("rst_bus_err",  64'(mem_bus_err),  64'd0);
        rst_n = 1'b1;
        step();

        // Single-cycle table
        for (int i = 0; i < 7; i++) begin
            EX_MEM = vecs[i].ex;
            #1;
            check($sformatf("v%0d_stall", i),  64'(mem_stall),         64'(vecs[i].stall));
            check($sformatf("v%0d_fwd_rw", i), 64'(MEM_RegWrite),      64'(vecs[i].ex[71]));
            check($sformatf("v%0d_fwd_rg", i), 64'(MEM_WriteRegister), 64'(vecs[i].ex[68:64]));
            check($sformatf("v%0d_fwd_d", i),  64'(MEM_RegWriteData),  64'(vecs[i].fwd_data));
            check($sformatf("v%0d_req", i),    64'(bus.mem_req),       64'd0);
            step();
            check($sformatf("v%0d_wb", i),     64'(MEM_WB),            64'(vecs[i].wb));
            check($sformatf("v%0d_mis", i),    64'(mem_misalign),      64'(vecs[i].mis));
            check($sformatf("v%0d_berr", i),   64'(mem_bus_err),       64'd0);
        end

        // lw 0x100, ready on the second BUSY cycle
        rs = req_cnt;
        ss = stall_cnt;
        EX_MEM = mk(32'h0040_0010, 2'b01, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_0100, 32'h0);
        #1;
        check("lw_idle_stall", 64'(mem_stall),   64'd1);
        check("lw_idle_req",   64'(bus.mem_req), 64'd0);
        step();
        check("lw_b1_req",   64'(bus.mem_req),  64'd1);
        check("lw_b1_we",    64'(bus.mem_we),   64'd0);
        check("lw_b1_addr",  64'(bus.mem_addr), 64'h100);
        check("lw_b1_wb",    64'(MEM_WB),       64'd0);
        step();
        check("lw_b2_req",   64'(bus.mem_req),  64'd1);
        check("lw_b2_stall", 64'(mem_stall),    64'd1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        check("lw_done_req",   64'(bus.mem_req), 64'd0);
        check("lw_done_stall", 64'(mem_stall),   64'd0);
        check("lw_done_wb",    64'(MEM_WB),      64'd0);
        step();
        EX_MEM = nop;
        check("lw_wb",        64'(MEM_WB),          64'({1'b1, 5'd10, 32'hDEAD_BEEF}));
        check("lw_req_cyc",   64'(req_cnt - rs),    64'd2);
        check("lw_stall_cyc", 64'(stall_cnt - ss),  64'd3);

        // sw 0x104, ready immediately
        rs = req_cnt;
        EX_MEM = mk(32'h0040_0014, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0104, 32'hCAFE_F00D);
        #1;
        check("sw_idle_stall", 64'(mem_stall), 64'd1);
        step();
        check("sw_req",   64'(bus.mem_req),   64'd1);
        check("sw_we",    64'(bus.mem_we),    64'd1);
        check("sw_addr",  64'(bus.mem_addr),  64'h104);
        check("sw_wdata", 64'(bus.mem_wdata), 64'hCAFE_F00D);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        check("sw_done_req", 64'(bus.mem_req), 64'd0);
        check("sw_done_wb",  64'(MEM_WB),      64'd0);
        step();
        EX_MEM = nop;
        check("sw_wb",      64'(MEM_WB),       64'({1'b0, 5'd0, 32'h0000_0104}));
        check("sw_req_cyc", 64'(req_cnt - rs), 64'd1);

        // Timeout: ready never arrives, TIMEOUT=4
        rs = req_cnt;
        bus.mem_rdata = 32'hBADB_AD00;
        EX_MEM = mk(32'h0040_0018, 2'b01, 1'b1, 1'b0, 1'b1, 5'd12, 32'h0000_0200, 32'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("to_b%0d_req", c),   64'(bus.mem_req), 64'd1);
            check($sformatf("to_b%0d_stall", c), 64'(mem_stall),   64'd1);
        end
        step();
        check("to_done_req",   64'(bus.mem_req), 64'd0);
        check("to_done_stall", 64'(mem_stall),   64'd0);
        check("to_done_berr",  64'(mem_bus_err), 64'd0);
        step();
        EX_MEM = nop;
        check("to_wb",      64'(MEM_WB),       64'({1'b0, 5'd12, 32'h0}));
        check("to_berr",    64'(mem_bus_err),  64'd1);
        check("to_req_cyc", 64'(req_cnt - rs), 64'd4);
        step();
        check("to_berr_clr", 64'(mem_bus_err), 64'd0);
        check("to_nop_wb",   64'(MEM_WB),      64'd0);
        bus.mem_rdata = 32'h0;

        // Reset asserted while BUSY
        EX_MEM = mk(32'h0040_001C, 2'b01, 1'b1, 1'b0, 1'b1, 5'd13, 32'h0000_0300, 32'h0);
        step();
        step();
        check("rb_req_busy", 64'(bus.mem_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rb_req_drop", 64'(bus.mem_req), 64'd0);
        check("rb_wb",       64'(MEM_WB),      64'd0);
        check("rb_we",       64'(bus.mem_we),  64'd0);
        EX_MEM = mk(32'h0040_0020, 2'b00, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_0042, 32'h0);
        #1;
        rst_n = 1'b1;
        step();
        check("rb_idle_wb",  64'(MEM_WB),      64'({1'b1, 5'd5, 32'h42}));
        check("rb_idle_req", 64'(bus.mem_req), 64'd0);
        check("rb_berr",     64'(mem_bus_err), 64'd0);
        step();
        check("rb_req2",  64'(bus.mem_req), 64'd0);
        check("rb_berr2", 64'(mem_bus_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
